// File: rtl/bus_transceiver_seq.sv
// bus_transceiver_seq
//   Clocked bidirectional transceiver between an internal data path and an external
//   shared bus. Each command arrives through a valid/ready handshake. A command either
//   drives a latched word onto the bus or receives the bus into zi_out. Dead turnaround
//   cycles are inserted whenever the bus direction changes, so the two ends never drive
//   the bus at the same time.
//
// Ports
//   sysclk     in   system clock, rising edge
//   sys_rst    in   synchronous active-high reset
//   tn         in   test enable; 0 isolates the external bus (io_oe=0, io_out=0)
//   cmd_valid  in   command request
//   cmd_dir    in   0 = drive a_in onto the bus, 1 = receive the bus into zi_out
//   cmd_ready  out  command accepted when cmd_valid && cmd_ready
//   a_in       in   internal data to drive, latched at accept
//   io_in      in   external bus input
//   io_out     out  external bus output value (0 whenever io_oe is low)
//   io_oe      out  external bus output enable
//   zi_out     out  last captured bus value
//   zi_valid   out  one-cycle pulse, concurrent with a zi_out update
//   busy       out  FSM not idle
//
// Parameters
//   WIDTH          data width of the internal and external buses
//   TURN_CYCLES    dead cycles on a direction change, 0..7
//   DRIVE_CYCLES   cycles io_oe stays high per drive command, 1..15
//   SAMPLE_CYCLES  settle cycles before io_in is captured, 1..15
module bus_transceiver_seq #(
  parameter int unsigned WIDTH         = 16,
  parameter int unsigned TURN_CYCLES   = 1,
  parameter int unsigned DRIVE_CYCLES  = 1,
  parameter int unsigned SAMPLE_CYCLES = 1
) (
  input  logic             sysclk,
  input  logic             sys_rst,
  input  logic             tn,
  input  logic             cmd_valid,
  input  logic             cmd_dir,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] io_in,
  output logic [WIDTH-1:0] io_out,
  output logic             io_oe,
  output logic [WIDTH-1:0] zi_out,
  output logic             zi_valid,
  output logic             busy
);

  typedef enum logic [1:0] {
    StIdle,
    StTurn,
    StDrive,
    StSample
  } state_e;

  // Counter reload values. Each phase lasts (load + 1) cycles.
  // The turn load is guarded so that TURN_CYCLES = 0 never underflows.
  localparam bit         TurnEn     = (TURN_CYCLES != 0);
  localparam logic [3:0] TurnLoad   = TurnEn ? 4'(TURN_CYCLES - 1) : 4'd0;
  localparam logic [3:0] DriveLoad  = 4'(DRIVE_CYCLES - 1);
  localparam logic [3:0] SampleLoad = 4'(SAMPLE_CYCLES - 1);

  state_e             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic               dir_q, dir_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   zi_out_q, zi_out_d;
  logic               zi_valid_q, zi_valid_d;
  logic               io_oe_q, io_oe_d;
  logic [WIDTH-1:0]   io_out_q, io_out_d;
  logic               accept;

  // Ready is a pure function of state and reset, so an upstream source may
  // present a command in the very first idle cycle after a previous one.
  assign cmd_ready = (state_q == StIdle) && !sys_rst;
  assign accept    = cmd_valid && cmd_ready;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dir_d      = dir_q;
    a_d        = a_q;
    zi_out_d   = zi_out_q;
    zi_valid_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          dir_d = cmd_dir;
          if (!cmd_dir) begin
            a_d = a_in;
          end
          if (TurnEn && (cmd_dir != dir_q)) begin
            state_d = StTurn;
            cnt_d   = TurnLoad;
          end else if (!cmd_dir) begin
            state_d = StDrive;
            cnt_d   = DriveLoad;
          end else begin
            state_d = StSample;
            cnt_d   = SampleLoad;
          end
        end
      end

      StTurn: begin
        if (cnt_q == 4'd0) begin
          // dir_q already holds the direction of the pending command.
          if (!dir_q) begin
            state_d = StDrive;
            cnt_d   = DriveLoad;
          end else begin
            state_d = StSample;
            cnt_d   = SampleLoad;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      StDrive: begin
        if (cnt_q == 4'd0) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      StSample: begin
        if (cnt_q == 4'd0) begin
          zi_out_d   = io_in;
          zi_valid_d = 1'b1;
          state_d    = StIdle;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase

    // Bus outputs are decoded from the next state so they are registered and
    // line up exactly with the DRIVE state; the value is zeroed whenever the
    // enable is low so a stale word is never presented.
    io_oe_d  = tn && (state_d == StDrive);
    io_out_d = io_oe_d ? a_d : '0;
  end

  always_ff @(posedge sysclk) begin
    if (sys_rst) begin
      state_q    <= StIdle;
      cnt_q      <= 4'd0;
      dir_q      <= 1'b1;
      a_q        <= '0;
      zi_out_q   <= '0;
      zi_valid_q <= 1'b0;
      io_oe_q    <= 1'b0;
      io_out_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dir_q      <= dir_d;
      a_q        <= a_d;
      zi_out_q   <= zi_out_d;
      zi_valid_q <= zi_valid_d;
      io_oe_q    <= io_oe_d;
      io_out_q   <= io_out_d;
    end
  end

  assign io_oe    = io_oe_q;
  assign io_out   = io_out_q;
  assign zi_out   = zi_out_q;
  assign zi_valid = zi_valid_q;
  assign busy     = (state_q != StIdle);

endmodule

// File: tb/tb_bus_transceiver_seq.sv
// Testbench for bus_transceiver_seq. A driver issues directed and random commands;
// a reference model predicts, per accepted command, the bus cycles and captured
// values and pushes them into a scoreboard. A monitor compares DUT outputs every
// cycle on the falling edge.
module tb_bus_transceiver_seq;

  localparam int W      = 16;
  localparam int TURN   = 1;
  localparam int DRIVE  = 4;
  localparam int SAMPLE = 2;
  localparam int HIST   = 8192;

  logic         sysclk;
  logic         sys_rst;
  logic         tn;
  logic         cmd_valid;
  logic         cmd_dir;
  logic         cmd_ready;
  logic [W-1:0] a_in;
  logic [W-1:0] io_in;
  logic [W-1:0] io_out;
  logic         io_oe;
  logic [W-1:0] zi_out;
  logic         zi_valid;
  logic         busy;

  bus_transceiver_seq #(
    .WIDTH        (W),
    .TURN_CYCLES  (TURN),
    .DRIVE_CYCLES (DRIVE),
    .SAMPLE_CYCLES(SAMPLE)
  ) dut (
    .sysclk   (sysclk),
    .sys_rst  (sys_rst),
    .tn       (tn),
    .cmd_valid(cmd_valid),
    .cmd_dir  (cmd_dir),
    .cmd_ready(cmd_ready),
    .a_in     (a_in),
    .io_in    (io_in),
    .io_out   (io_out),
    .io_oe    (io_oe),
    .zi_out   (zi_out),
    .zi_valid (zi_valid),
    .busy     (busy)
  );

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  int cyc = 0;
  always @(posedge sysclk) cyc <= cyc + 1;

  typedef struct {
    bit           rx;   // 1 = capture pulse, 0 = one driven bus cycle
    int           cyc;
    logic [W-1:0] val;
  } exp_t;

  exp_t         sb[$];
  logic [W-1:0] io_hist [HIST];

  // Reference model state.
  int           m_free  = 0;    // first cycle the DUT is idle again
  int           m_acc   = -10;  // cycle of the last accept
  bit           m_dir   = 1'b1;
  logic [W-1:0] exp_zi  = '0;
  bit           rst_pend = 1'b0;
  bit           acc_now;
  bit           check_en = 1'b0;
  logic         exp_busy;

  int total = 0;
  int bad   = 0;

  task automatic check(input bit ok, input string nm, input logic [31:0] got,
                       input logic [31:0] want);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%h want=%h", nm, cyc, got, want);
    end
  endtask

  // One clock cycle of stimulus. Acceptance is decided by the model.
  task automatic step(input bit v, input bit d, input logic [W-1:0] a, input bit t,
                      input bit r);
    int c;
    int turn;
    exp_t keep[$];
    @(posedge sysclk);
    #1;
    c = cyc;
    if (rst_pend) begin
      // Reset at the previous edge: everything predicted after it is void.
      keep = {};
      foreach (sb[i]) if (sb[i].cyc <= c - 1) keep.push_back(sb[i]);
      sb     = keep;
      m_free = c;
      m_acc  = c - 1;
      m_dir  = 1'b1;
      exp_zi = '0;
    end
    rst_pend  = r;
    sys_rst   = r;
    cmd_valid = v;
    cmd_dir   = d;
    a_in      = a;
    io_in     = io_hist[c];
    acc_now   = 1'b0;
    if (!r && c >= m_free) begin
      tn = t;
      if (v) begin
        acc_now = 1'b1;
        turn    = (d != m_dir && TURN > 0) ? TURN : 0;
        m_acc   = c;
        m_dir   = d;
        if (!d) begin
          if (t) for (int k = 1; k <= DRIVE; k++) sb.push_back('{1'b0, c + turn + k, a});
          m_free = c + turn + DRIVE + 1;
        end else begin
          sb.push_back('{1'b1, c + turn + SAMPLE + 1, io_hist[c + turn + SAMPLE]});
          m_free = c + turn + SAMPLE + 1;
        end
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, tn, 1'b0);
  endtask

  task automatic issue(input bit d, input logic [W-1:0] a, input bit t);
    int n = 0;
    do begin
      step(1'b1, d, a, t, 1'b0);
      n++;
    end while (!acc_now && n < 64);
    if (!acc_now) check(1'b0, "accept_timeout", 32'(n), 32'd64);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a bus cycle or capture.
  always @(negedge sysclk) begin
    if (check_en) begin
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
        check(1'b0, sb[0].rx ? "missing_capture" : "missing_drive", 32'd0, 32'(sb[0].val));
        sb.delete(0);
      end
      if (io_oe) begin
        if (sb.size() > 0 && sb[0].cyc == cyc && !sb[0].rx) begin
          check(io_out == sb[0].val, "io_out_drive", 32'(io_out), 32'(sb[0].val));
          sb.delete(0);
        end else begin
          check(1'b0, "unexpected_io_oe", 32'd1, 32'd0);
        end
      end else begin
        check(io_out == '0, "io_out_released", 32'(io_out), 32'd0);
      end
      if (zi_valid) begin
        if (sb.size() > 0 && sb[0].cyc == cyc && sb[0].rx) begin
          check(zi_out == sb[0].val, "zi_out_capture", 32'(zi_out), 32'(sb[0].val));
          exp_zi = sb[0].val;
          sb.delete(0);
        end else begin
          check(1'b0, "unexpected_zi_valid", 32'd1, 32'd0);
        end
      end else begin
        check(zi_out == exp_zi, "zi_out_hold", 32'(zi_out), 32'(exp_zi));
      end
      exp_busy = (cyc > m_acc) && (cyc < m_free);
      check(busy == exp_busy, "busy", 32'(busy), 32'(exp_busy));
      check(cmd_ready == (!exp_busy && !sys_rst), "cmd_ready", 32'(cmd_ready),
            32'(!exp_busy && !sys_rst));
    end
  end

  initial begin
    for (int i = 0; i < HIST; i++) io_hist[i] = W'($urandom);
    sys_rst   = 1'b1;
    tn        = 1'b1;
    cmd_valid = 1'b0;
    cmd_dir   = 1'b1;
    a_in      = '0;
    io_in     = '0;

    step(1'b0, 1'b1, '0, 1'b1, 1'b1);
    check_en = 1'b1;
    step(1'b0, 1'b1, '0, 1'b1, 1'b1);
    idle(2);

    // Drive out of reset passes through a turnaround.
    issue(1'b0, 16'hA5A5, 1'b1);
    idle(6);
    // Drive then receive: direction change before the capture.
    issue(1'b0, 16'h1234, 1'b1);
    issue(1'b1, 16'h0000, 1'b1);
    idle(6);
    // Back-to-back receives, no turnaround.
    issue(1'b1, 16'h0000, 1'b1);
    issue(1'b1, 16'h0000, 1'b1);
    idle(4);
    // Isolated bus: timing unchanged, nothing driven.
    issue(1'b0, 16'hFFFF, 1'b0);
    idle(6);
    // Valid held and a_in toggling while busy; the latched value must persist.
    issue(1'b0, 16'hC3C3, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, W'($urandom), 1'b1, 1'b0);
    idle(6);
    // Reset for two cycles in the middle of a drive, then drive again.
    issue(1'b0, 16'h5A5A, 1'b1);
    idle(2);
    step(1'b0, 1'b0, '0, 1'b1, 1'b1);
    step(1'b0, 1'b0, '0, 1'b1, 1'b1);
    issue(1'b0, 16'h0F0F, 1'b1);
    idle(8);

    for (int i = 0; i < 1500; i++) begin
      step(($urandom % 100) < 60, 1'($urandom % 2), W'($urandom), ($urandom % 4) != 0,
           ($urandom % 100) < 2);
    end
    idle(30);

    check(sb.size() == 0, "scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
